y86_inst_encoder: RTL and testbench

//  Converts Y86-64 instruction fields (icode, ifun, rA, rB, valC) into the byte

---
 rtl/y86_pkg.sv | 36 +++
 rtl/y86_inst_len.sv | 48 ++++
 rtl/y86_inst_encoder.sv | 168 ++++++++++++++++
 tb/tb_y86_inst_encoder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg
// Shared Y86-64 definitions. The fetch/decode blocks and the instruction
// encoder all use these icode values and the "no register" code, so keeping
// them in one place guarantees the encoder emits exactly what decode expects.
//
// Contents:
//   I_HALT .. I_POPQ  instruction codes 0x0 .. 0xB
//   RNONE             register specifier meaning "no register" (0xF)
//   instInfo_t        per-icode shape: byte length, reg byte, valC, legality
// ---------------------------------------------------------------------------
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE    = 4'hF;

    typedef struct packed {
        logic [3:0] len;
        logic       hasReg;
        logic       hasValC;
        logic       legal;
    } instInfo_t;

endpackage

// File: rtl/y86_inst_len.sv
// ---------------------------------------------------------------------------
// y86_inst_len
// Purely combinational lookup from an icode to the shape of its encoding.
//
// Ports:
//   icode  in   4            instruction code
//   info   out  instInfo_t   {len, hasReg, hasValC, legal}
//
// Unknown icodes (0xC..0xF) come back with legal=0 and len=0 so the caller
// can reject them without starting a byte stream.
// ---------------------------------------------------------------------------
module y86_inst_len
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output instInfo_t  info
);

    // Table of encodings: 1 byte for the bare opcodes, 2 when a register
    // byte follows, 9 when only an 8-byte constant follows, 10 for both.
    always_comb begin
        info = '0;
        case (icode)
            I_HALT, I_NOP, I_RET: begin
                info.len   = 4'd1;
                info.legal = 1'b1;
            end
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
                info.len    = 4'd2;
                info.hasReg = 1'b1;
                info.legal  = 1'b1;
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                info.len     = 4'd10;
                info.hasReg  = 1'b1;
                info.hasValC = 1'b1;
                info.legal   = 1'b1;
            end
            I_JXX, I_CALL: begin
                info.len     = 4'd9;
                info.hasValC = 1'b1;
                info.legal   = 1'b1;
            end
            default: info = '0;
        endcase
    end

endmodule

// File: rtl/y86_inst_encoder.sv
// ---------------------------------------------------------------------------
// y86_inst_encoder
// Turns Y86-64 instruction fields into the byte stream written into
// instruction memory, one byte per out_valid/out_ready handshake, each byte
// tagged with its address. The PC advances by the instruction length once
// the final byte has been taken.
//
// Ports:
//   clk, rst_n            clock / asynchronous active-low reset
//   org_we, org_addr      relocate the PC (only while idle)
//   in_valid, in_ready    instruction handshake
//   icode, ifun, rA, rB   instruction fields
//   valC                  64-bit constant / destination
//   out_valid, out_ready  byte handshake toward memory
//   out_addr, out_byte    byte address and encoded byte
//   out_last              current byte ends the instruction
//   err_illegal           one-cycle pulse after an unknown icode was dropped
//   pc                    address where the next instruction will start
// ---------------------------------------------------------------------------
module y86_inst_encoder
    import y86_pkg::*;
#(
    parameter int                 ADDR_W    = 64,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              org_we,
    input  logic [ADDR_W-1:0] org_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic [63:0]       valC,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [7:0]        out_byte,
    output logic              out_last,
    output logic              err_illegal,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    logic [0:0]  state;
    logic [3:0]  index;
    logic        errFlag;
    logic [3:0]  curIcode, curIfun, curRA, curRB, curLen;
    logic        curHasReg, curHasValC;
    logic [63:0] curValC;

    instInfo_t   info;
    logic [3:0]  fixIfun, fixRA, fixRB;
    logic        accept, transfer;
    logic [2:0]  regOffset, valcPos;
    logic [7:0]  byteSel;

    y86_inst_len lenUnit (
        .icode (icode),
        .info  (info)
    );

    assign in_ready    = (state == ST_IDLE);
    assign accept      = in_valid && in_ready;
    assign out_valid   = (state == ST_EMIT);
    assign transfer    = out_valid && out_ready;
    assign out_last    = (state == ST_EMIT) && (index == curLen - 4'd1);
    assign out_addr    = pc + {{(ADDR_W-4){1'b0}}, index};
    assign out_byte    = byteSel;
    assign err_illegal = errFlag;

    // Canonicalise fields before latching: single-byte opcodes carry no
    // function code, irmovq has no source register, and push/pop have no
    // second register, so those nibbles are driven to fixed values instead
    // of whatever the source happened to present.
    always_comb begin
        fixIfun = ifun;
        fixRA   = rA;
        fixRB   = rB;
        if (icode == I_HALT || icode == I_NOP || icode == I_RET) begin
            fixIfun = 4'h0;
        end
        if (icode == I_IRMOVQ) begin
            fixRA = RNONE;
        end
        if (icode == I_PUSHQ || icode == I_POPQ) begin
            fixRB = RNONE;
        end
    end

    // Pick the byte for the current index. valC starts right after the
    // register byte when there is one, otherwise right after byte 0; the
    // 3-bit subtraction wraps so index 9 (or 8) lands on valC byte 7.
    always_comb begin
        byteSel   = 8'h00;
        regOffset = curHasReg ? 3'd2 : 3'd1;
        valcPos   = index[2:0] - regOffset;
        if (state == ST_EMIT) begin
            if (index == 4'd0) begin
                byteSel = {curIcode, curIfun};
            end else if (curHasReg && index == 4'd1) begin
                byteSel = {curRA, curRB};
            end else if (curHasValC) begin
                byteSel = curValC[{valcPos, 3'b000} +: 8];
            end
        end
    end

    // Main sequencer. In IDLE it can relocate the PC and accept an
    // instruction in the same cycle; since out_addr is pc+index, a
    // coincident org_we naturally places the instruction at org_addr.
    // In EMIT it steps through the bytes and only moves the PC once the
    // final byte has been accepted. Illegal icodes never leave IDLE and
    // just raise the error flag for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pc         <= BASE_ADDR;
            index      <= 4'd0;
            errFlag    <= 1'b0;
            curIcode   <= 4'h0;
            curIfun    <= 4'h0;
            curRA      <= 4'h0;
            curRB      <= 4'h0;
            curLen     <= 4'd0;
            curHasReg  <= 1'b0;
            curHasValC <= 1'b0;
            curValC    <= 64'h0;
        end else begin
            errFlag <= accept && !info.legal;
            case (state)
                ST_IDLE: begin
                    if (org_we) begin
                        pc <= org_addr;
                    end
                    if (accept && info.legal) begin
                        state      <= ST_EMIT;
                        index      <= 4'd0;
                        curIcode   <= icode;
                        curIfun    <= fixIfun;
                        curRA      <= fixRA;
                        curRB      <= fixRB;
                        curLen     <= info.len;
                        curHasReg  <= info.hasReg;
                        curHasValC <= info.hasValC;
                        curValC    <= valC;
                    end
                end
                default: begin
                    if (transfer) begin
                        if (out_last) begin
                            state <= ST_IDLE;
                            index <= 4'd0;
                            pc    <= pc + {{(ADDR_W-4){1'b0}}, curLen};
                        end else begin
                            index <= index + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_y86_inst_encoder.sv
// ---------------------------------------------------------------------------
// tb_y86_inst_encoder
// Directed bench for the Y86-64 instruction encoder. Expected byte streams
// are written out by hand from the Y86-64 encoding rules.
// ---------------------------------------------------------------------------
module tb_y86_inst_encoder;

    logic        clk;
    logic        rst_n;
    logic        org_we;
    logic [63:0] org_addr;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_addr;
    logic [7:0]  out_byte;
    logic        out_last;
    logic        err_illegal;
    logic [63:0] pc;

    int          errors;
    int          checks;
    logic [7:0]  expBytes [10];

    y86_inst_encoder #(.ADDR_W(64), .BASE_ADDR(64'h0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .org_we      (org_we),
        .org_addr    (org_addr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .icode       (icode),
        .ifun        (ifun),
        .rA          (rA),
        .rB          (rB),
        .valC        (valC),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_addr    (out_addr),
        .out_byte    (out_byte),
        .out_last    (out_last),
        .err_illegal (err_illegal),
        .pc          (pc)
    );

    // 10 ns clock; all checks happen on the falling edge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one instruction for a single rising edge, starting from a
    // falling edge and returning on the next falling edge.
    task automatic applyStimulus(input logic [3:0] ic, input logic [3:0] fn,
                                 input logic [3:0] ra, input logic [3:0] rb,
                                 input logic [63:0] vc);
        icode    = ic;
        ifun     = fn;
        rA       = ra;
        rB       = rb;
        valC     = vc;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Walk n bytes of expBytes out of the encoder starting at addr0. With
    // toggle set, out_ready alternates every cycle so stalled bytes are seen
    // twice and must not change. When complete is set, the idle state and
    // the advanced PC are checked after the final byte.
    task automatic checkStream(input string name, input int n, input int len,
                               input logic [63:0] addr0, input bit toggle,
                               input bit complete, input logic [63:0] expPc);
        int idx;
        int budget;
        idx    = 0;
        budget = 0;
        while (idx < n && budget < 60) begin
            out_ready = toggle ? ~out_ready : 1'b1;
            checkOutput($sformatf("%s valid[%0d]", name, idx), {63'h0, out_valid}, 64'h1);
            checkOutput($sformatf("%s inReady[%0d]", name, idx), {63'h0, in_ready}, 64'h0);
            checkOutput($sformatf("%s byte[%0d]", name, idx), {56'h0, out_byte}, {56'h0, expBytes[idx]});
            checkOutput($sformatf("%s addr[%0d]", name, idx), out_addr, addr0 + 64'(idx));
            checkOutput($sformatf("%s last[%0d]", name, idx), {63'h0, out_last},
                        {63'h0, (idx == len - 1)});
            if (out_ready && out_valid) idx++;
            budget++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        if (idx < n) begin
            checkOutput($sformatf("%s timeout", name), 64'(idx), 64'(n));
        end
        if (complete) begin
            checkOutput($sformatf("%s idleValid", name), {63'h0, out_valid}, 64'h0);
            checkOutput($sformatf("%s idleReady", name), {63'h0, in_ready}, 64'h1);
            checkOutput($sformatf("%s pc", name), pc, expPc);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        org_we    = 1'b0;
        org_addr  = 64'h0;
        in_valid  = 1'b0;
        icode     = 4'h0;
        ifun      = 4'h0;
        rA        = 4'h0;
        rB        = 4'h0;
        valC      = 64'h0;
        out_ready = 1'b1;

        // Reset values.
        @(negedge clk);
        checkOutput("rst inReady", {63'h0, in_ready}, 64'h1);
        checkOutput("rst outValid", {63'h0, out_valid}, 64'h0);
        checkOutput("rst outLast", {63'h0, out_last}, 64'h0);
        checkOutput("rst err", {63'h0, err_illegal}, 64'h0);
        checkOutput("rst outByte", {56'h0, out_byte}, 64'h0);
        checkOutput("rst outAddr", out_addr, 64'h0);
        checkOutput("rst pc", pc, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // irmovq with rA deliberately not F: the encoder must force it.
        $display("[TB] irmovq");
        applyStimulus(4'h3, 4'h0, 4'h5, 4'h2, 64'h0123456789ABCDEF);
        expBytes = '{8'h30, 8'hF2, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        checkStream("irmovq", 10, 10, 64'h0, 1'b0, 1'b1, 64'd10);

        // call after relocating to 0x40.
        $display("[TB] call");
        org_we   = 1'b1;
        org_addr = 64'h40;
        @(negedge clk);
        org_we   = 1'b0;
        checkOutput("org pc", pc, 64'h40);
        applyStimulus(4'h8, 4'h0, 4'h3, 4'h4, 64'h100);
        expBytes = '{8'h80, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        checkStream("call", 9, 9, 64'h40, 1'b0, 1'b1, 64'h49);

        // halt then ret under alternating backpressure; ret ifun must be zeroed.
        $display("[TB] halt/ret backpressure");
        out_ready = 1'b1;
        applyStimulus(4'h0, 4'h7, 4'h1, 4'h2, 64'h0);
        expBytes[0] = 8'h00;
        checkStream("halt", 1, 1, 64'h49, 1'b1, 1'b1, 64'h4A);
        out_ready = 1'b1;
        applyStimulus(4'h9, 4'h3, 4'h1, 4'h2, 64'h0);
        expBytes[0] = 8'h90;
        checkStream("ret", 1, 1, 64'h4A, 1'b1, 1'b1, 64'h4B);

        // Illegal icode: dropped, one-cycle error pulse, PC untouched.
        $display("[TB] illegal icode");
        applyStimulus(4'hC, 4'h0, 4'h1, 4'h2, 64'h0);
        checkOutput("ill err", {63'h0, err_illegal}, 64'h1);
        checkOutput("ill outValid", {63'h0, out_valid}, 64'h0);
        checkOutput("ill pc", pc, 64'h4B);
        @(negedge clk);
        checkOutput("ill errDrop", {63'h0, err_illegal}, 64'h0);
        checkOutput("ill outValid2", {63'h0, out_valid}, 64'h0);
        checkOutput("ill inReady", {63'h0, in_ready}, 64'h1);

        // OPq placed at the top of memory in the same cycle as org_we; PC wraps.
        $display("[TB] OPq wrap");
        org_we   = 1'b1;
        org_addr = 64'hFFFF_FFFF_FFFF_FFFE;
        applyStimulus(4'h6, 4'h0, 4'h2, 4'h3, 64'h0);
        org_we   = 1'b0;
        expBytes[0] = 8'h60;
        expBytes[1] = 8'h23;
        checkStream("opq", 2, 2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 64'h0);

        // rmmovq at 0x200, reset asynchronously after byte 3 has gone out.
        $display("[TB] reset mid-emit");
        org_we   = 1'b1;
        org_addr = 64'h200;
        @(negedge clk);
        org_we   = 1'b0;
        applyStimulus(4'h4, 4'h0, 4'h1, 4'h2, 64'h1122334455667788);
        expBytes = '{8'h40, 8'h12, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        checkStream("rmmovq", 4, 10, 64'h200, 1'b0, 1'b0, 64'h0);
        checkOutput("rmmovq byte4", {56'h0, out_byte}, 64'h66);
        checkOutput("rmmovq addr4", out_addr, 64'h204);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst outValid", {63'h0, out_valid}, 64'h0);
        checkOutput("arst pc", pc, 64'h0);
        checkOutput("arst inReady", {63'h0, in_ready}, 64'h1);
        checkOutput("arst outByte", {56'h0, out_byte}, 64'h0);
        checkOutput("arst outAddr", out_addr, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(4'h1, 4'h5, 4'h1, 4'h2, 64'h0);
        expBytes[0] = 8'h10;
        checkStream("nop", 1, 1, 64'h0, 1'b0, 1'b1, 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
